uart_tx_framer: RTL and testbench

- Serial transmitter for the APB serial peripheral: accepts one parallel byte per valid/ready handshake and emits an asynchronous frame on serial_out.
- Frame order: start bit, data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Bit timing comes from a programmable clocks-per-bit divider.
- The APB register block drives it; its output goes to the pad.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_bit_timer.sv | 28 ++
 rtl/uart_tx_framer.sv | 129 ++++++++++++
 tb/tb_uart_tx_framer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int   DEFAULT_DATA_BITS = 8;
    localparam int   MAX_DATA_BITS     = 9;
    localparam logic IDLE_LEVEL        = 1'b1;

    // Zero-extended data does not change the XOR, so one width serves every DATA_BITS.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Free-running 1..period counter; bit_end marks the last count of each period.
module uart_tx_bit_timer #(
    parameter int NUM_BAUD_BITS = 14
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [NUM_BAUD_BITS-1:0] period,
    output logic                     bit_end
);

    logic [NUM_BAUD_BITS-1:0] count;

    assign bit_end = enable && (count == period);

    // Clear and wrap both load 1 so consecutive periods have no dead cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= NUM_BAUD_BITS'(1);
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per valid/ready handshake, framed as start/data/parity/stop.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int NUM_BAUD_BITS = 14,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_BAUD_BITS-1:0] baud_div,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    input  logic                     two_stop,
    input  logic [DATA_BITS-1:0]     tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam logic [3:0] IDX_PERIOD = 4'(DATA_BITS);

    tx_state_t                state, state_nx;
    logic [DATA_BITS-1:0]     shreg;
    logic [NUM_BAUD_BITS-1:0] baud_q, period;
    logic                     parity_en_q, parity_bit_q, two_stop_q;
    logic                     stop_second, stop_second_nx;
    logic                     serial_nx;
    logic                     take, in_idle, in_data_step;
    logic                     bit_end, idx_end;

    assign in_idle      = (state == IDLE);
    assign tx_ready     = in_idle;
    assign tx_busy      = !in_idle;
    assign take         = tx_valid && tx_ready;
    assign in_data_step = (state == DATA) && bit_end;
    assign period       = (baud_q == '0) ? NUM_BAUD_BITS'(1) : baud_q;

    uart_tx_bit_timer #(.NUM_BAUD_BITS(NUM_BAUD_BITS)) u_bit_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (in_idle),
        .enable  (tx_busy),
        .period  (period),
        .bit_end (bit_end)
    );

    // Same counter, stepped once per data bit: idx_end flags the last data bit.
    uart_tx_bit_timer #(.NUM_BAUD_BITS(4)) u_bit_index (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (in_idle),
        .enable  (in_data_step),
        .period  (IDX_PERIOD),
        .bit_end (idx_end)
    );

    always_comb begin
        state_nx       = state;
        serial_nx      = serial_out;
        stop_second_nx = stop_second;
        tx_done        = 1'b0;
        case (state)
            IDLE: begin
                stop_second_nx = 1'b0;
                if (take) begin
                    state_nx  = START;
                    serial_nx = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_nx  = DATA;
                serial_nx = shreg[0];
            end
            // shreg shifts on this same edge, so the next bit is shreg[1] now.
            DATA: if (bit_end) begin
                if (!idx_end) begin
                    serial_nx = shreg[1];
                end else if (parity_en_q) begin
                    state_nx  = PARITY;
                    serial_nx = parity_bit_q;
                end else begin
                    state_nx  = STOP;
                    serial_nx = IDLE_LEVEL;
                end
            end
            PARITY: if (bit_end) begin
                state_nx  = STOP;
                serial_nx = IDLE_LEVEL;
            end
            STOP: if (bit_end) begin
                if (two_stop_q && !stop_second) begin
                    stop_second_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                    tx_done  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            serial_out  <= IDLE_LEVEL;
            stop_second <= 1'b0;
        end else begin
            state       <= state_nx;
            serial_out  <= serial_nx;
            stop_second <= stop_second_nx;
        end
    end

    // Frame configuration is captured once per handshake and frozen for the frame.
    always_ff @(posedge clk) begin
        if (take) begin
            shreg        <= tx_data;
            baud_q       <= baud_div;
            parity_en_q  <= parity_en;
            two_stop_q   <= two_stop;
            parity_bit_q <= parity_of(MAX_DATA_BITS'(tx_data), parity_odd);
        end else if (in_data_step) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: expected frames queued by stimulus, checked by a line monitor.
module tb_uart_tx_framer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [13:0] baud_div = '0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, serial_out, tx_busy, tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [255:0] bits;
        int           len;
        int           gap;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_framer #(.NUM_BAUD_BITS(14), .DATA_BITS(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // slots holds the hand-written frame, first transmitted bit leftmost.
    task automatic send(input string name, input logic [7:0] d, input logic [13:0] bd,
                        input logic pe, input logic po, input logic ts,
                        input logic [15:0] slots, input int ns, input int gap,
                        input bit push, input bit hold);
        exp_t e;
        int   p;
        int   w;
        p      = (bd == 0) ? 1 : int'(bd);
        e.bits = '0;
        e.len  = ns * p;
        e.gap  = gap;
        e.name = name;
        for (int i = 0; i < ns; i++)
            for (int k = 0; k < p; k++)
                e.bits[i*p + k] = slots[ns-1-i];
        if (push) exp_q.push_back(e);
        tx_data    = d;
        baud_div   = bd;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        tx_valid   = 1'b1;
        w = 0;
        while (!tx_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_handshake: tx_ready never rose", name);
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Line monitor
    logic [255:0] cap_bits = '0;
    int           cap_len  = 0;
    int           idle_cnt = 0;
    int           gap_seen = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            cap_len  = 0;
            cap_bits = '0;
            idle_cnt = 0;
        end else if (tx_busy) begin
            if (cap_len == 0) gap_seen = idle_cnt;
            if (cap_len < 256) cap_bits[cap_len] = serial_out;
            cap_len++;
            if (tx_done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: frame of %0d cycles with nothing queued", cap_len);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cap_len != e.len) begin
                        n_fail++;
                        $display("FAIL %s_len: got %0d cycles expected %0d", e.name, cap_len, e.len);
                    end
                    n_tests++;
                    if (cap_bits != e.bits) begin
                        n_fail++;
                        $display("FAIL %s_bits: got %h expected %h", e.name, cap_bits, e.bits);
                    end
                    if (e.gap >= 0) begin
                        n_tests++;
                        if (gap_seen != e.gap) begin
                            n_fail++;
                            $display("FAIL %s_gap: got %0d expected %0d", e.name, gap_seen, e.gap);
                        end
                    end
                end
                cap_len  = 0;
                cap_bits = '0;
                idle_cnt = 0;
            end
        end else begin
            idle_cnt++;
            n_tests++;
            if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_line: serial_out=%b tx_ready=%b tx_done=%b expected 1 1 0",
                         serial_out, tx_ready, tx_done);
            end
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_serial_out", int'(serial_out), 1);
        chk("reset_tx_ready",   int'(tx_ready),   1);
        chk("reset_tx_busy",    int'(tx_busy),    0);
        chk("reset_tx_done",    int'(tx_done),    0);
        n_rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        send("basic_a5",   8'hA5, 14'd4, 1'b0, 1'b0, 1'b0, 16'b0101001011,  10, -1, 1'b1, 1'b0);
        send("parity_even", 8'h07, 14'd2, 1'b1, 1'b0, 1'b0, 16'b01110000011, 11, -1, 1'b1, 1'b0);
        send("parity_odd",  8'h07, 14'd2, 1'b1, 1'b1, 1'b0, 16'b01110000001, 11, -1, 1'b1, 1'b0);

        send("b2b_00", 8'h00, 14'd3, 1'b0, 1'b0, 1'b1, 16'b00000000011, 11, -1, 1'b1, 1'b1);
        send("b2b_ff", 8'hFF, 14'd3, 1'b0, 1'b0, 1'b1, 16'b01111111111, 11,  1, 1'b1, 1'b0);

        // The second call rewrites the inputs while the 1-clock-per-bit frame is in flight.
        send("cfg_p1_5a", 8'h5A, 14'd0, 1'b0, 1'b0, 1'b0, 16'b0010110101, 10, -1, 1'b1, 1'b1);
        send("cfg_p8_c3", 8'hC3, 14'd8, 1'b0, 1'b0, 1'b0, 16'b0110000111, 10,  1, 1'b1, 1'b0);

        // Aborted frame: reset lands in the middle of data bit 3 (a 0 bit of 0x81).
        send("abort_81", 8'h81, 14'd4, 1'b0, 1'b0, 1'b0, 16'b0100000011, 10, -1, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #3;
        chk("midreset_line_before", int'(serial_out), 0);
        n_rst = 1'b0;
        #1;
        chk("midreset_serial_out", int'(serial_out), 1);
        chk("midreset_tx_busy",    int'(tx_busy),    0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        send("after_reset_3c", 8'h3C, 14'd2, 1'b0, 1'b0, 1'b0, 16'b0001111001, 10, -1, 1'b1, 1'b0);

        w = 0;
        while ((exp_q.size() != 0 || tx_busy) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("frames_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
